// File: rtl/sram_zbt_ctrl.sv
// sram_zbt_ctrl
//   Responder for the SRAM arbiter request port. It drives a pipelined
//   (ZBT) SRAM and owns the physical pins. It accepts one request per cycle.
//   An all-zero byte mask is a read. Read data returns with a fixed latency.
//
//   Optional feature macro: SRAM_ZBT_CTRL_OUTREG_EN
//     defined   -> extra register on sram_data_out / sram_data_out_valid,
//                  read latency 5
//     undefined -> read latency 4
//
// Ports
//   sram_clock           sole clock, rising edge
//   reset                asynchronous, active-low
//   sram_addr_valid      request present
//   sram_ready           request accepted when high together with valid
//   sram_addr            word address
//   sram_data_in         write data
//   sram_write_mask      active-high byte enables, all zero = read
//   sram_data_out        read data, holds its value between strobes
//   sram_data_out_valid  one-cycle strobe per read
//   zbt_addr             SRAM address pins
//   zbt_ce_b             SRAM chip enable (active-low)
//   zbt_we_b             SRAM write enable (active-low)
//   zbt_bw_b             SRAM byte writes (active-low)
//   zbt_oe_b             SRAM output enable (active-low)
//   zbt_dq_out           write data to pad
//   zbt_dq_oe            pad driver enable
//   zbt_dq_in            data from pad
module sram_zbt_ctrl #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    sram_clock,
  input  logic                    reset,
  input  logic                    sram_addr_valid,
  output logic                    sram_ready,
  input  logic [ADDR_WIDTH-1:0]   sram_addr,
  input  logic [DATA_WIDTH-1:0]   sram_data_in,
  input  logic [DATA_WIDTH/8-1:0] sram_write_mask,
  output logic [DATA_WIDTH-1:0]   sram_data_out,
  output logic                    sram_data_out_valid,
  output logic [ADDR_WIDTH-1:0]   zbt_addr,
  output logic                    zbt_ce_b,
  output logic                    zbt_we_b,
  output logic [DATA_WIDTH/8-1:0] zbt_bw_b,
  output logic                    zbt_oe_b,
  output logic [DATA_WIDTH-1:0]   zbt_dq_out,
  output logic                    zbt_dq_oe,
  input  logic [DATA_WIDTH-1:0]   zbt_dq_in
);

  logic                  rdy_en;
  logic                  rd_last;
  logic                  req_wr;
  logic                  accept;

  logic                  rd_p0, wr_p0;
  logic                  rd_p1, wr_p1;
  logic                  rd_p2, wr_p2;
  logic [DATA_WIDTH-1:0] data_p0, data_p1, data_p2;

  logic                  vld_p3;
  logic [DATA_WIDTH-1:0] rdata_p3;

  assign req_wr = |sram_write_mask;

  // A write directly after an accepted read is held off one cycle. This
  // prevents our pad driver from turning on in the cycle after the SRAM
  // stopped driving the DQ bus.
  assign sram_ready = rdy_en & ~(rd_last & req_wr);
  assign accept     = sram_addr_valid & sram_ready;

  // The SRAM output buffers are always enabled. Bus direction is set by
  // zbt_dq_oe and by the read/write command timing.
  assign zbt_oe_b   = ~reset;

  assign zbt_dq_out = data_p2;
  assign zbt_dq_oe  = wr_p2;

  // ---- command stage: request -> zbt pins (cycle n+1) ----
  always_ff @(posedge sram_clock or negedge reset) begin
    if (!reset) begin
      rdy_en   <= 1'b0;
      rd_last  <= 1'b0;
      zbt_addr <= '0;
      zbt_ce_b <= 1'b1;
      zbt_we_b <= 1'b1;
      zbt_bw_b <= '1;
    end else begin
      rdy_en   <= 1'b1;
      rd_last  <= accept & ~req_wr;
      zbt_ce_b <= ~accept;
      zbt_we_b <= ~(accept & req_wr);
      zbt_bw_b <= accept ? ~sram_write_mask : '1;
      if (accept) begin
        zbt_addr <= sram_addr;
      end
    end
  end

  // ---- op pipeline p0 (n+1) -> p1 (n+2) -> p2 (n+3, DQ phase) ----
  always_ff @(posedge sram_clock or negedge reset) begin
    if (!reset) begin
      rd_p0   <= 1'b0;
      wr_p0   <= 1'b0;
      rd_p1   <= 1'b0;
      wr_p1   <= 1'b0;
      rd_p2   <= 1'b0;
      wr_p2   <= 1'b0;
      data_p2 <= '0;
    end else begin
      rd_p0   <= accept & ~req_wr;
      wr_p0   <= accept & req_wr;
      rd_p1   <= rd_p0;
      wr_p1   <= wr_p0;
      rd_p2   <= rd_p1;
      wr_p2   <= wr_p1;
      data_p2 <= data_p1;
    end
  end

  always_ff @(posedge sram_clock) begin
    data_p0 <= sram_data_in;
    data_p1 <= data_p0;
  end

  // ---- capture stage: DQ sampled at end of n+3, presented in n+4 ----
  always_ff @(posedge sram_clock or negedge reset) begin
    if (!reset) begin
      vld_p3   <= 1'b0;
      rdata_p3 <= '0;
    end else begin
      vld_p3 <= rd_p2;
      if (rd_p2) begin
        rdata_p3 <= zbt_dq_in;
      end
    end
  end

`ifdef SRAM_ZBT_CTRL_OUTREG_EN
  logic                  vld_p4;
  logic [DATA_WIDTH-1:0] rdata_p4;

  // ---- output register stage: presented in n+5 ----
  always_ff @(posedge sram_clock or negedge reset) begin
    if (!reset) begin
      vld_p4   <= 1'b0;
      rdata_p4 <= '0;
    end else begin
      vld_p4 <= vld_p3;
      if (vld_p3) begin
        rdata_p4 <= rdata_p3;
      end
    end
  end

  assign sram_data_out       = rdata_p4;
  assign sram_data_out_valid = vld_p4;
`else
  assign sram_data_out       = rdata_p3;
  assign sram_data_out_valid = vld_p3;
`endif

endmodule

// File: tb/tb_sram_zbt_ctrl.sv
// tb_sram_zbt_ctrl
//   Bench for sram_zbt_ctrl. It has a behavioural ZBT SRAM on the pins and
//   a reference model of the request interface. The model tracks memory
//   contents, the expected command and drive cycles, and the expected read
//   returns. Directed scenarios run first, then a random request phase.
module tb_sram_zbt_ctrl;

  localparam int AW = 18;
  localparam int DW = 32;
`ifdef SRAM_ZBT_CTRL_OUTREG_EN
  localparam int RD_LAT = 5;
`else
  localparam int RD_LAT = 4;
`endif

  logic          sram_clock = 1'b0;
  logic          reset = 1'b1;
  logic          sram_addr_valid = 1'b0;
  logic          sram_ready;
  logic [AW-1:0] sram_addr = '0;
  logic [DW-1:0] sram_data_in = '0;
  logic [3:0]    sram_write_mask = '0;
  logic [DW-1:0] sram_data_out;
  logic          sram_data_out_valid;
  logic [AW-1:0] zbt_addr;
  logic          zbt_ce_b, zbt_we_b, zbt_oe_b, zbt_dq_oe;
  logic [3:0]    zbt_bw_b;
  logic [DW-1:0] zbt_dq_out;
  logic [DW-1:0] zbt_dq_in = '0;

  sram_zbt_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .sram_clock(sram_clock), .reset(reset),
    .sram_addr_valid(sram_addr_valid), .sram_ready(sram_ready),
    .sram_addr(sram_addr), .sram_data_in(sram_data_in),
    .sram_write_mask(sram_write_mask), .sram_data_out(sram_data_out),
    .sram_data_out_valid(sram_data_out_valid), .zbt_addr(zbt_addr),
    .zbt_ce_b(zbt_ce_b), .zbt_we_b(zbt_we_b), .zbt_bw_b(zbt_bw_b),
    .zbt_oe_b(zbt_oe_b), .zbt_dq_out(zbt_dq_out), .zbt_dq_oe(zbt_dq_oe),
    .zbt_dq_in(zbt_dq_in)
  );

  always #5 sram_clock = ~sram_clock;

  int cyc = 0;
  always @(posedge sram_clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural ZBT SRAM (2-cycle pipelined) ----------------
  typedef struct packed {
    logic          vld;
    logic          wr;
    logic [AW-1:0] a;
    logic [3:0]    bw;
  } ph_t;

  logic [DW-1:0] sram_mem [int];
  ph_t ph_q1 = '0;
  ph_t ph_q2 = '0;

  function automatic logic [DW-1:0] sram_get(input logic [AW-1:0] a);
    return sram_mem.exists(int'(a)) ? sram_mem[int'(a)] : '0;
  endfunction

  always @(posedge sram_clock) begin
    logic [DW-1:0] w;
    if (ph_q2.vld && ph_q2.wr && zbt_dq_oe) begin
      w = sram_get(ph_q2.a);
      for (int i = 0; i < 4; i++)
        if (!ph_q2.bw[i]) w[8*i +: 8] = zbt_dq_out[8*i +: 8];
      sram_mem[int'(ph_q2.a)] = w;
    end
    if (ph_q1.vld && !ph_q1.wr) zbt_dq_in <= sram_get(ph_q1.a);
    else                        zbt_dq_in <= $urandom;
    ph_q2 <= ph_q1;
    ph_q1 <= '{vld: !zbt_ce_b, wr: !zbt_we_b, a: zbt_addr, bw: zbt_bw_b};
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [AW-1:0] a;
    logic          we_b;
    logic [3:0]    bw;
  } cmd_t;
  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } rd_t;

  logic [DW-1:0] ref_mem [int];
  cmd_t          exp_cmd [int];
  logic [DW-1:0] exp_wr  [int];
  rd_t           rdq[$];
  logic [DW-1:0] last_out = '0;
  int            rd_acc_cyc = -10;

  function automatic logic [DW-1:0] ref_get(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
  endfunction

  task automatic model_accept(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] m);
    logic [DW-1:0] w;
    rd_t r;
    exp_cmd[cyc + 1] = '{a: a, we_b: (m == 4'h0), bw: ~m};
    if (m != 4'h0) begin
      w = ref_get(a);
      for (int i = 0; i < 4; i++)
        if (m[i]) w[8*i +: 8] = d[8*i +: 8];
      ref_mem[int'(a)] = w;
      exp_wr[cyc + 3] = d;
    end else begin
      r.due = cyc + RD_LAT;
      r.d   = ref_get(a);
      rdq.push_back(r);
      rd_acc_cyc = cyc;
    end
  endtask

  task automatic model_reset();
    exp_cmd.delete();
    exp_wr.delete();
    rdq.delete();
    last_out   = '0;
    rd_acc_cyc = -10;
  endtask

  // ---------------- pin / response monitor (opposite edge) ----------------
  always @(negedge sram_clock) begin
    bit ev;
    if (!reset) begin
      chk("rst_ctrl", {sram_ready, sram_data_out_valid, zbt_ce_b, zbt_we_b,
                       zbt_bw_b, zbt_oe_b, zbt_dq_oe},
                      {1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0});
      chk("rst_data", {zbt_addr, zbt_dq_out, sram_data_out}, '0);
    end else begin
      if (exp_cmd.exists(cyc)) begin
        chk("cmd", {zbt_ce_b, zbt_we_b, zbt_bw_b, zbt_addr},
                   {1'b0, exp_cmd[cyc].we_b, exp_cmd[cyc].bw, exp_cmd[cyc].a});
        exp_cmd.delete(cyc);
      end else begin
        chk("idle_cmd", {zbt_ce_b, zbt_we_b, zbt_bw_b}, {1'b1, 1'b1, 4'hF});
      end
      if (exp_wr.exists(cyc)) begin
        chk("dq_drive", {zbt_dq_oe, zbt_dq_out}, {1'b1, exp_wr[cyc]});
        exp_wr.delete(cyc);
      end else begin
        chk("dq_oe_idle", zbt_dq_oe, 1'b0);
      end
      chk("oe_b", zbt_oe_b, 1'b0);
      ev = (rdq.size() > 0) && (rdq[0].due == cyc);
      chk("rd_valid", sram_data_out_valid, ev);
      if (ev) begin
        chk("rd_data", sram_data_out, rdq[0].d);
        last_out = rdq[0].d;
        void'(rdq.pop_front());
      end else begin
        chk("rd_hold", sram_data_out, last_out);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] m,
                       input bit v, output bit acc);
    bit er;
    @(negedge sram_clock);
    sram_addr_valid = v;
    sram_addr       = a;
    sram_data_in    = d;
    sram_write_mask = m;
    #1;
    er = !((rd_acc_cyc == cyc - 1) && (m != 4'h0));
    chk("ready", sram_ready, er);
    acc = v && er;
    if (acc) model_accept(a, d, m);
  endtask

  task automatic do_req(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] m,
                        output int tries);
    bit acc;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 3) begin
      drive(a, d, m, 1'b1, acc);
      tries++;
    end
    chk("accepted", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive('0, '0, 4'h0, 1'b0, acc);
  endtask

  task automatic reset_pulse(input int n);
    @(negedge sram_clock);
    #2;
    reset = 1'b0;
    model_reset();
    repeat (n) @(negedge sram_clock);
    #2;
    reset = 1'b1;
    model_reset();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int  tries;
    bit  acc;
    bit  v;
    logic [3:0] m;

    #1 reset = 1'b0;
    repeat (3) @(negedge sram_clock);
    #2 reset = 1'b1;
    model_reset();
    @(negedge sram_clock);

    // write then read back
    do_req(18'h00010, 32'hDEADBEEF, 4'hF, tries);
    idle(3);
    chk("s1_dq_oe",  zbt_dq_oe,  1'b1);
    chk("s1_dq_out", zbt_dq_out, 32'hDEADBEEF);
    do_req(18'h00010, '0, 4'h0, tries);
    idle(RD_LAT);
    chk("s1_valid", sram_data_out_valid, 1'b1);
    chk("s1_data",  sram_data_out, 32'hDEADBEEF);
    idle(2);

    // partial byte write merge
    do_req(18'h5, 32'h11223344, 4'hF, tries);
    do_req(18'h5, 32'hAABBCCDD, 4'b0101, tries);
    idle(1);
    chk("s2_bw", zbt_bw_b, 4'b1010);
    do_req(18'h5, '0, 4'h0, tries);
    idle(RD_LAT + 1);
    chk("s2_data", sram_data_out, 32'h11BB33DD);

    // four back-to-back reads
    for (int i = 0; i < 4; i++) begin
      do_req(AW'(i), '0, 4'h0, tries);
      chk("s3_tries", tries, 1);
    end
    idle(RD_LAT + 2);

    // read then write: one turnaround bubble
    do_req(18'h7, '0, 4'h0, tries);
    do_req(18'h7, 32'hCAFEF00D, 4'hF, tries);
    chk("s4_tries", tries, 2);
    idle(8);

    // reset during an in-flight read
    do_req(18'h00010, '0, 4'h0, tries);
    idle(1);
    reset_pulse(3);
    idle(RD_LAT + 3);
    do_req(18'h7, '0, 4'h0, tries);
    idle(RD_LAT + 1);
    chk("s5_post_rst", sram_data_out, 32'hCAFEF00D);

    // random traffic over a small address window
    for (int i = 0; i < 200; i++) begin
      v = ($urandom_range(0, 3) != 0);
      m = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if (!v) m = 4'h0;
      drive(AW'($urandom_range(0, 15)), $urandom, m, v, acc);
    end
    idle(RD_LAT + 4);
    chk("drain", rdq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
